// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: splits 64-bit bus beats into two 32-bit
// instructions, tags each with its byte address, and queues them for the
// decoder. Enqueueing stops once a return instruction has been buffered.
module inst_fetch_buffer #(
  parameter int BEAT_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_start,
  input  logic [63:0]           line_pc,
  input  logic                  beat_valid,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  beat_ready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_word,
  output logic [63:0]           inst_pc,
  input  logic                  flush,
  output logic                  halt_seen,
  output logic [4:0]            count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] RET_INSN = 32'h00008067;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    beat_idx_q, beat_idx_d;
  logic [63:0]   base_pc_q, base_pc_d;
  logic          halt_q, halt_d;

  logic [31:0]   word_mem [DEPTH];
  logic [63:0]   pc_mem   [DEPTH];

  logic          beat_fire, pop, push_two;
  logic [31:0]   lo_word, hi_word;
  logic          lo_is_ret, hi_is_ret;
  logic [63:0]   cur_base, lo_pc, hi_pc;
  logic [2:0]    cur_idx;
  logic [CW-1:0] push_cnt;

  // Handshake outputs; reset forces the block to look empty and closed.
  assign beat_ready = (count_q <= CW'(DEPTH - 2)) & ~halt_q & ~flush & ~reset;
  assign inst_valid = (count_q != '0) & ~reset;
  assign count      = reset ? 5'd0 : 5'(count_q);
  assign halt_seen  = halt_q;
  assign inst_word  = word_mem[rd_ptr_q];
  assign inst_pc    = pc_mem[rd_ptr_q];

  // Beat decode: a line_start in the same cycle supplies the base and index 0.
  always_comb begin
    beat_fire = beat_valid & beat_ready;
    pop       = inst_valid & inst_ready;
    lo_word   = beat_data[31:0];
    hi_word   = beat_data[63:32];
    lo_is_ret = (lo_word == RET_INSN);
    hi_is_ret = (hi_word == RET_INSN);
    cur_base  = line_start ? line_pc : base_pc_q;
    cur_idx   = line_start ? 3'd0 : beat_idx_q;
    lo_pc     = cur_base + {58'd0, cur_idx, 3'b000};
    hi_pc     = lo_pc + 64'd4;
    push_two  = beat_fire & ~lo_is_ret;
    if (!beat_fire)     push_cnt = CW'(0);
    else if (lo_is_ret) push_cnt = CW'(1);
    else                push_cnt = CW'(2);
  end

  // Next-state logic; flush overrides push, pop and line_start but keeps base_pc.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    beat_idx_d = beat_idx_q;
    base_pc_d  = base_pc_q;
    halt_d     = halt_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      beat_idx_d = 3'd0;
      halt_d     = 1'b0;
    end else begin
      if (line_start) begin
        base_pc_d  = line_pc;
        beat_idx_d = 3'd0;
      end
      if (beat_fire) begin
        wr_ptr_d   = wr_ptr_q + AW'(push_cnt);
        beat_idx_d = cur_idx + 3'd1;
        if (lo_is_ret || hi_is_ret) halt_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + push_cnt - CW'(pop);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      beat_idx_q <= 3'd0;
      base_pc_q  <= 64'd0;
      halt_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      beat_idx_q <= beat_idx_d;
      base_pc_q  <= base_pc_d;
      halt_q     <= halt_d;
    end
  end

  // FIFO storage writes: lower word at wr_ptr, upper word in the next slot.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count gates validity, so stale contents are never observed.
    if (beat_fire) begin
      word_mem[wr_ptr_q] <= lo_word;
      pc_mem[wr_ptr_q]   <= lo_pc;
      if (push_two) begin
        word_mem[wr_ptr_q + AW'(1)] <= hi_word;
        pc_mem[wr_ptr_q + AW'(1)]   <= hi_pc;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: a reference model predicts each
// enqueued (word, pc) pair into a queue that is compared as the DUT pops.
module tb_inst_fetch_buffer;

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [63:0] line_pc;
  logic        beat_valid;
  logic [63:0] beat_data;
  logic        beat_ready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        flush;
  logic        halt_seen;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  ent_t        sb[$];
  logic [63:0] m_base;
  logic [2:0]  m_idx;

  inst_fetch_buffer #(.BEAT_WIDTH(64), .DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_pc    (line_pc),
    .beat_valid (beat_valid),
    .beat_data  (beat_data),
    .beat_ready (beat_ready),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_word  (inst_word),
    .inst_pc    (inst_pc),
    .flush      (flush),
    .halt_seen  (halt_seen),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every popped head against the oldest predicted entry.
  always @(negedge clk) begin
    if (inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", inst_valid, 1'b0);
      end else begin
        ent_t e;
        e = sb.pop_front();
        check("head_word", inst_word, e.word);
        check("head_pc", inst_pc, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mkbeat(input int n);
    mkbeat = {32'h00A0_0001 + 32'(2 * n), 32'h00A0_0000 + 32'(2 * n)};
  endfunction

  // Offer one beat, wait for acceptance, and predict what it enqueues.
  task automatic send_beat(input logic ls, input logic [63:0] lpc, input logic [63:0] data);
    bit          ok;
    logic [63:0] b, pc;
    logic [2:0]  ix;
    line_start = ls;
    line_pc    = lpc;
    beat_valid = 1'b1;
    beat_data  = data;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (beat_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("beat_timeout", beat_ready, 1'b1);
    end else begin
      b  = ls ? lpc : m_base;
      ix = ls ? 3'd0 : m_idx;
      pc = b + {58'd0, ix, 3'b000};
      sb.push_back('{word: data[31:0], pc: pc});
      if (data[31:0] != 32'h00008067) sb.push_back('{word: data[63:32], pc: pc + 64'd4});
      m_base = b;
      m_idx  = ix + 3'd1;
    end
    step();
    line_start = 1'b0;
    beat_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    inst_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !inst_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", inst_valid, 1'b0);
    check("drained_count", count, 5'd0);
    step();
    inst_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
    m_idx = 3'd0;
  endtask

  initial begin
    reset = 1'b1; line_start = 1'b0; line_pc = '0; beat_valid = 1'b0;
    beat_data = '0; inst_ready = 1'b0; flush = 1'b0;
    m_base = '0; m_idx = 3'd0;

    // Reset state
    @(negedge clk);
    check("rst_count", count, 5'd0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_beat_ready", beat_ready, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("post_rst_ready", beat_ready, 1'b1);
    check("post_rst_halt", halt_seen, 1'b0);

    // Basic line: two beats, decoder always ready
    inst_ready = 1'b1;
    send_beat(1'b1, 64'h1000, 64'h00000013_00100093);
    check("latency_valid", inst_valid, 1'b1);
    send_beat(1'b0, 64'h0, 64'h00000013_00000013);
    drain();

    // Fill to full with decoder stalled
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(i == 0, 64'h2000, mkbeat(i));
    beat_valid = 1'b1;
    beat_data  = mkbeat(99);
    @(negedge clk);
    check("full_count", count, 5'd16);
    check("full_ready", beat_ready, 1'b0);
    step();
    beat_valid = 1'b0;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    check("one_free_count", count, 5'd15);
    check("one_free_ready", beat_ready, 1'b0);
    step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    @(negedge clk);
    check("two_free_count", count, 5'd14);
    check("two_free_ready", beat_ready, 1'b1);
    step();
    drain();

    // Index wrap: nine beats on one line
    inst_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_beat(i == 0, 64'h4000, mkbeat(10 + i));
    drain();

    // Return in the lower word: only it is enqueued
    send_beat(1'b1, 64'h3000, 64'h00000013_00008067);
    beat_valid = 1'b1;
    beat_data  = mkbeat(50);
    @(negedge clk);
    check("lo_ret_halt", halt_seen, 1'b1);
    check("lo_ret_count", count, 5'd1);
    check("lo_ret_ready", beat_ready, 1'b0);
    step();
    beat_valid = 1'b0;
    drain();
    check("halt_sticky", halt_seen, 1'b1);
    do_flush();
    check("flush_halt_clr", halt_seen, 1'b0);

    // Return in the upper word: both words enqueued
    send_beat(1'b1, 64'h3100, 64'h00008067_00000013);
    check("hi_ret_halt", halt_seen, 1'b1);
    check("hi_ret_count", count, 5'd2);
    drain();
    do_flush();

    // Flush beats a simultaneous push and pop; base_pc survives
    for (int i = 0; i < 3; i++) send_beat(i == 0, 64'h5000, mkbeat(20 + i));
    check("pre_flush_count", count, 5'd6);
    flush      = 1'b1;
    beat_valid = 1'b1;
    beat_data  = mkbeat(30);
    inst_ready = 1'b1;
    step();
    flush      = 1'b0;
    beat_valid = 1'b0;
    inst_ready = 1'b0;
    sb.delete();
    m_idx = 3'd0;
    check("flush_count", count, 5'd0);
    check("flush_valid", inst_valid, 1'b0);
    check("flush_halt", halt_seen, 1'b0);
    send_beat(1'b0, 64'h0, mkbeat(31));
    drain();

    // Reset mid-line with count=10 and halt set
    for (int i = 0; i < 4; i++) send_beat(i == 0, 64'h6000, mkbeat(40 + i));
    send_beat(1'b0, 64'h0, 64'h00008067_00000013);
    check("pre_rst_count", count, 5'd10);
    check("pre_rst_halt", halt_seen, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("in_rst_count", count, 5'd0);
    check("in_rst_valid", inst_valid, 1'b0);
    check("in_rst_ready", beat_ready, 1'b0);
    step();
    reset = 1'b0;
    sb.delete();
    m_base = '0;
    m_idx  = 3'd0;
    check("post_rst_count", count, 5'd0);
    check("post_rst_halt2", halt_seen, 1'b0);
    check("post_rst_valid", inst_valid, 1'b0);
    send_beat(1'b0, 64'h0, mkbeat(60));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
